// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter: merges the never-stalling W-stage write with buffered MDU results.
// Optional trace printing of issued writes and kills is enabled by defining WB_ARB_TRACE_EN.
module grf_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_we,
    input  logic [4:0]    pipe_a3,
    input  logic [31:0]   pipe_wd,
    input  logic [31:0]   pipe_pc,
    input  logic          mdu_valid,
    output logic          mdu_ready,
    input  logic [4:0]    mdu_a3,
    input  logic [31:0]   mdu_wd,
    input  logic [31:0]   mdu_pc,
    output logic          grf_we,
    output logic [4:0]    grf_a3,
    output logic [31:0]   grf_wd,
    output logic [31:0]   grf_pc,
    output logic [31:0]   pend_mask,
    output logic [AW:0]   fifo_cnt
);

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [4:0]       ent_a3 [DEPTH];
    logic [31:0]      ent_wd [DEPTH];
    logic [31:0]      ent_pc [DEPTH];
    logic [DEPTH-1:0] ent_live;
    logic [DEPTH-1:0] live_nxt;
    logic [DEPTH-1:0] kill;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;

    logic             pipe_real;
    logic             xfer;
    logic             xfer_keep;
    logic             head_valid;
    logic             head_live;
    logic             pop;
    logic             push;
    logic             bypass;
    logic             iss_we;
    logic [4:0]       iss_a3;
    logic [31:0]      iss_wd;
    logic [31:0]      iss_pc;

    // An MDU result aimed at the register the pipe writes this cycle is older, so it is dropped.
    always_comb begin
        pipe_real  = pipe_we && (pipe_a3 != 5'd0);
        mdu_ready  = !reset && (count < FULL_CNT);
        xfer       = mdu_valid && mdu_ready;
        xfer_keep  = xfer && (mdu_a3 != 5'd0) && !(pipe_real && (mdu_a3 == pipe_a3));
        head_valid = (count != '0);
        head_live  = head_valid && ent_live[rd_ptr];
        pop        = head_valid && (!ent_live[rd_ptr] || !pipe_real);
        bypass     = !pipe_real && !head_valid && xfer_keep;
        push       = xfer_keep && !bypass;
    end

    always_comb begin
        iss_we = 1'b0;
        iss_a3 = pipe_a3;
        iss_wd = pipe_wd;
        iss_pc = pipe_pc;
        if (pipe_real) begin
            iss_we = 1'b1;
        end else if (head_live) begin
            iss_we = 1'b1;
            iss_a3 = ent_a3[rd_ptr];
            iss_wd = ent_wd[rd_ptr];
            iss_pc = ent_pc[rd_ptr];
        end else if (bypass) begin
            iss_we = 1'b1;
            iss_a3 = mdu_a3;
            iss_wd = mdu_wd;
            iss_pc = mdu_pc;
        end
    end

    always_comb begin
        kill      = '0;
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill[i] = pipe_real && ent_live[i] && (ent_a3[i] == pipe_a3);
            if (ent_live[i]) begin
                pend_mask[ent_a3[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
        live_nxt = ent_live & ~kill;
        if (pop) begin
            live_nxt[rd_ptr] = 1'b0;
        end
        if (push) begin
            live_nxt[wr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ent_live <= '0;
        end else begin
            ent_live <= live_nxt;
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ent_a3[wr_ptr] <= mdu_a3;
            ent_wd[wr_ptr] <= mdu_wd;
            ent_pc[wr_ptr] <= mdu_pc;
        end
    end

    // Address/data/pc keep their last issued values when nothing is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            grf_we <= 1'b0;
            grf_a3 <= '0;
            grf_wd <= '0;
            grf_pc <= '0;
        end else begin
            grf_we <= iss_we;
            if (iss_we) begin
                grf_a3 <= iss_a3;
                grf_wd <= iss_wd;
                grf_pc <= iss_pc;
            end
        end
    end

    assign fifo_cnt = count;

`ifdef WB_ARB_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (iss_we) begin
                $display("%d@%h: $%d <= %h %s", $time, iss_pc, iss_a3, iss_wd,
                         pipe_real ? "(pipe)" : "(mdu)");
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (kill[i]) begin
                    $display("%d: kill $%d", $time, ent_a3[i]);
                end
            end
        end
    end
`endif

endmodule
